// File: rtl/csr_master_apb_pkg.sv
// Shared bus types for the APB-to-CSR bridge: APB target request/response
// and CSR master request/response records.
package csr_master_apb_pkg;

    typedef struct packed {
        logic        psel;
        logic        penable;
        logic        pwrite;
        logic [31:0] paddr;
        logic [31:0] pwdata;
    } t_apb_request;

    typedef struct packed {
        logic        pready;
        logic [31:0] prdata;
        logic        pslverr;
    } t_apb_response;

    typedef struct packed {
        logic        valid;
        logic        read_not_write;
        logic [15:0] select;
        logic [15:0] address;
        logic [31:0] data;
    } t_csr_request;

    typedef struct packed {
        logic        acknowledge;
        logic        read_data_valid;
        logic        read_data_error;
        logic [31:0] read_data;
    } t_csr_response;

    localparam t_csr_request  CSR_REQUEST_IDLE  = '0;
    localparam t_apb_response APB_RESPONSE_IDLE = '0;

endpackage

// File: rtl/csr_master_apb_if.sv
// Bus interfaces for the bridge: the APB link (bridge is the slave side)
// and the CSR link (bridge is the master side).
interface apb_bus_if;
    import csr_master_apb_pkg::*;

    t_apb_request  apb_request;
    t_apb_response apb_response;

    modport master (output apb_request, input  apb_response);
    modport slave  (input  apb_request, output apb_response);
endinterface

interface csr_bus_if;
    import csr_master_apb_pkg::*;

    t_csr_request  csr_request;
    t_csr_response csr_response;

    modport master (output csr_request, input  csr_response);
    modport slave  (input  csr_request, output csr_response);
endinterface

// File: rtl/csr_master_apb.sv
// APB target that forwards each transfer as a single CSR request and
// returns the CSR result to the APB master. All outputs are registered.
module csr_master_apb
    import csr_master_apb_pkg::*;
(
    input  logic      clk,
    input  logic      reset_n,
    apb_bus_if.slave  apb,
    csr_bus_if.master csr
);

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        WAIT_DATA,
        COMPLETE
    } t_state;

    t_state        state_q, state_d;
    t_csr_request  csr_request_q, csr_request_d;
    t_apb_response apb_response_q, apb_response_d;

    // State and output registers; reset abandons any transaction silently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            csr_request_q  <= CSR_REQUEST_IDLE;
            apb_response_q <= APB_RESPONSE_IDLE;
        end else begin
            state_q        <= state_d;
            csr_request_q  <= csr_request_d;
            apb_response_q <= apb_response_d;
        end
    end

    // Next state and next register values; pready is a one-cycle echo of COMPLETE.
    always_comb begin
        state_d               = state_q;
        csr_request_d         = csr_request_q;
        apb_response_d        = apb_response_q;
        apb_response_d.pready = (state_q == COMPLETE);

        case (state_q)
            IDLE: begin
                if (apb.apb_request.psel && !apb.apb_request.penable) begin
                    csr_request_d.valid          = 1'b1;
                    csr_request_d.read_not_write = !apb.apb_request.pwrite;
                    csr_request_d.select         = apb.apb_request.paddr[31:16];
                    csr_request_d.address        = apb.apb_request.paddr[15:0];
                    csr_request_d.data           = apb.apb_request.pwdata;
                    apb_response_d.prdata        = '0;
                    apb_response_d.pslverr       = 1'b0;
                    state_d                      = REQUEST;
                end
            end
            REQUEST: begin
                if (csr.csr_response.acknowledge) begin
                    csr_request_d.valid = 1'b0;
                    if (!csr_request_q.read_not_write) begin
                        state_d = COMPLETE;
                    end else if (csr.csr_response.read_data_valid) begin
                        apb_response_d.prdata  = csr.csr_response.read_data;
                        apb_response_d.pslverr = csr.csr_response.read_data_error;
                        state_d                = COMPLETE;
                    end else begin
                        state_d = WAIT_DATA;
                    end
                end
            end
            WAIT_DATA: begin
                if (csr.csr_response.read_data_valid) begin
                    apb_response_d.prdata  = csr.csr_response.read_data;
                    apb_response_d.pslverr = csr.csr_response.read_data_error;
                    state_d                = COMPLETE;
                end
            end
            COMPLETE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign apb.apb_response = apb_response_q;
    assign csr.csr_request  = csr_request_q;

endmodule

// File: tb/tb_csr_master_apb.sv
// Testbench for csr_master_apb: directed and randomized APB transfers
// against a scripted CSR target, checked against latency/data rules.
module tb_csr_master_apb;
    import csr_master_apb_pkg::*;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    int checks          = 0;
    int failures        = 0;
    int pready_pulses   = 0;
    int expected_pulses = 0;

    apb_bus_if apb_bus ();
    csr_bus_if csr_bus ();

    csr_master_apb dut (
        .clk     (clk),
        .reset_n (reset_n),
        .apb     (apb_bus),
        .csr     (csr_bus)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Count every pready pulse seen on the APB side.
    always @(negedge clk) begin
        if (apb_bus.apb_response.pready === 1'b1) pready_pulses++;
    end

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic drive_idle();
        apb_bus.apb_request  = '0;
        csr_bus.csr_response = '0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            drive_idle();
        end
    endtask

    // One APB transfer with a scripted CSR target. ack_wait = cycles valid is
    // held before ack; data_wait = cycles from ack to read data (0 = same cycle).
    task automatic apply_stimulus(input string tag, input bit is_write,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input int ack_wait, input int data_wait,
                                  input logic [31:0] rdata, input bit rerr,
                                  input bit drop_psel);
        int   ack_c, data_c, exp_c, seen_c, pulses;
        bit   valid_ok, fields_ok, exp_valid;
        logic [31:0] obs_prdata;
        logic        obs_pslverr;

        ack_c  = 1 + ack_wait;
        data_c = ack_c + data_wait;
        exp_c  = is_write ? ack_c + 2 : data_c + 2;

        @(negedge clk);
        apb_bus.apb_request.psel    = 1'b1;
        apb_bus.apb_request.penable = 1'b0;
        apb_bus.apb_request.pwrite  = is_write;
        apb_bus.apb_request.paddr   = addr;
        apb_bus.apb_request.pwdata  = wdata;
        csr_bus.csr_response        = '0;

        seen_c      = -1;
        pulses      = 0;
        valid_ok    = 1'b1;
        fields_ok   = 1'b1;
        obs_prdata  = 'x;
        obs_pslverr = 1'bx;

        for (int c = 1; c <= exp_c; c++) begin
            @(negedge clk);
            exp_valid = (c <= ack_c);
            if (csr_bus.csr_request.valid !== exp_valid) valid_ok = 1'b0;
            if (exp_valid && ((csr_bus.csr_request.select !== addr[31:16]) ||
                              (csr_bus.csr_request.address !== addr[15:0]) ||
                              (csr_bus.csr_request.data !== wdata) ||
                              (csr_bus.csr_request.read_not_write !== !is_write)))
                fields_ok = 1'b0;
            if (apb_bus.apb_response.pready === 1'b1) begin
                pulses++;
                if (seen_c < 0) begin
                    seen_c      = c;
                    obs_prdata  = apb_bus.apb_response.prdata;
                    obs_pslverr = apb_bus.apb_response.pslverr;
                end
            end

            if (drop_psel) begin
                apb_bus.apb_request.psel    = 1'b0;
                apb_bus.apb_request.penable = 1'b0;
            end else begin
                apb_bus.apb_request.penable = 1'b1;
            end
            csr_bus.csr_response.acknowledge =
                (c == ack_c) || (!is_write && c > ack_c && c < data_c);
            if (c == data_c) begin
                csr_bus.csr_response.read_data_valid = 1'b1;
                csr_bus.csr_response.read_data       = is_write ? (32'hBAD0_0000 | c) : rdata;
                csr_bus.csr_response.read_data_error = is_write ? 1'b1 : rerr;
            end else begin
                csr_bus.csr_response.read_data_valid = 1'b0;
                csr_bus.csr_response.read_data       = '0;
                csr_bus.csr_response.read_data_error = 1'b0;
            end
        end
        expected_pulses++;

        check_output({tag, ".valid_window"}, valid_ok, 1'b1);
        check_output({tag, ".fields"}, fields_ok, 1'b1);
        check_output({tag, ".pready_cycle"}, seen_c, exp_c);
        check_output({tag, ".pready_count"}, pulses, 1);
        check_output({tag, ".prdata"}, obs_prdata, is_write ? 32'h0 : rdata);
        check_output({tag, ".pslverr"}, obs_pslverr, is_write ? 1'b0 : rerr);
    endtask

    initial begin
        int          base;
        logic [31:0] r_addr, r_wdata, r_rdata;
        bit          r_write, r_err;
        int          r_ack, r_data;

        drive_idle();
        $display("[TB] start");

        // Reset values
        repeat (3) @(negedge clk);
        check_output("reset.valid", csr_bus.csr_request.valid, 1'b0);
        check_output("reset.csr_fields", csr_bus.csr_request, '0);
        check_output("reset.pready", apb_bus.apb_response.pready, 1'b0);
        check_output("reset.prdata", apb_bus.apb_response.prdata, 32'h0);
        check_output("reset.pslverr", apb_bus.apb_response.pslverr, 1'b0);
        reset_n = 1'b1;
        idle_cycles(2);

        // Directed cases
        apply_stimulus("write", 1'b1, 32'h0003_0010, 32'hDEAD_BEEF, 2, 0, 32'h0, 1'b0, 1'b0);
        apply_stimulus("read", 1'b0, 32'h0001_0004, 32'h0, 0, 1, 32'h1234_5678, 1'b0, 1'b0);
        idle_cycles(2);
        apply_stimulus("timeout_read", 1'b0, 32'h0002_0008, 32'h0, 4, 1, 32'h0, 1'b1, 1'b0);
        idle_cycles(1);
        apply_stimulus("same_cycle", 1'b0, 32'h0004_0020, 32'h0, 0, 0, 32'hA5A5_A5A5, 1'b0, 1'b0);
        idle_cycles(2);

        // Back-to-back write then read
        base = pready_pulses;
        apply_stimulus("b2b_write", 1'b1, 32'h0005_0100, 32'hCAFE_F00D, 0, 0, 32'h0, 1'b0, 1'b0);
        apply_stimulus("b2b_read", 1'b0, 32'h0005_0104, 32'h0, 1, 2, 32'h0BAD_CAFE, 1'b0, 1'b0);
        idle_cycles(2);
        check_output("b2b.pulses", pready_pulses - base, 2);

        // psel dropped mid-transfer still completes
        apply_stimulus("psel_drop", 1'b0, 32'h0006_0040, 32'h0, 2, 1, 32'h7777_1111, 1'b0, 1'b1);
        idle_cycles(2);

        // Reset while in REQUEST
        @(negedge clk);
        apb_bus.apb_request.psel   = 1'b1;
        apb_bus.apb_request.pwrite = 1'b1;
        apb_bus.apb_request.paddr  = 32'h0009_0030;
        apb_bus.apb_request.pwdata = 32'h1357_9BDF;
        @(negedge clk);
        apb_bus.apb_request.penable = 1'b1;
        check_output("rst_mid.valid_before", csr_bus.csr_request.valid, 1'b1);
        @(negedge clk);
        base = pready_pulses;
        #2 reset_n = 1'b0;
        #1;
        check_output("rst_mid.valid_now", csr_bus.csr_request.valid, 1'b0);
        check_output("rst_mid.select", csr_bus.csr_request.select, 16'h0);
        check_output("rst_mid.pready", apb_bus.apb_response.pready, 1'b0);
        @(negedge clk);
        drive_idle();
        reset_n = 1'b1;
        idle_cycles(4);
        check_output("rst_mid.no_pready", pready_pulses - base, 0);
        apply_stimulus("after_reset_write", 1'b1, 32'h000A_0050, 32'h2468_ACE0, 1, 0, 32'h0, 1'b0, 1'b0);
        idle_cycles(1);

        // Randomized transfers
        for (int i = 0; i < 20; i++) begin
            r_write = 1'($urandom_range(0, 1));
            r_addr  = $urandom;
            r_wdata = $urandom;
            r_rdata = $urandom;
            r_err   = 1'($urandom_range(0, 1));
            r_ack   = $urandom_range(0, 3);
            r_data  = $urandom_range(0, 3);
            apply_stimulus($sformatf("rand%0d", i), r_write, r_addr, r_wdata,
                           r_ack, r_data, r_rdata, r_err, 1'b0);
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
        end

        idle_cycles(3);
        check_output("total_pulses", pready_pulses, expected_pulses);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csr_master_apb.md
CSR_MASTER_APB -- requirements
Module: csr_master_apb

Interface
REQ-001 SHALL have ports: clk  in  1  clock, all state on rising edge.
REQ-002 SHALL have ports: reset_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have APB target inputs: apb_request.psel 1, .penable 1, .pwrite 1, .paddr 32, .pwdata 32.
REQ-004 SHALL have APB target outputs: apb_response.pready 1, .prdata 32, .pslverr 1.
REQ-005 SHALL have CSR master outputs: csr_request.valid 1, .read_not_write 1, .select 16, .address 16, .data 32.
REQ-006 SHALL have CSR master inputs: csr_response.acknowledge 1, .read_data_valid 1, .read_data_error 1, .read_data 32.
REQ-007 SHALL register every output (no combinational input-to-output path).

Function
REQ-008 SHALL implement FSM states IDLE, REQUEST, WAIT_DATA, COMPLETE.
REQ-009 SHALL in IDLE, on psel=1 and penable=0 (APB setup), capture:
- select = paddr[31:16]
- address = paddr[15:0]
- data = pwdata
- read_not_write = !pwrite
It SHALL then assert csr_request.valid next cycle and enter REQUEST.
REQ-010 SHALL in REQUEST hold valid and all request fields stable until a cycle with acknowledge=1 is sampled.
REQ-011 SHALL on that acknowledge deassert valid the following cycle and enter:
- COMPLETE for a write
- WAIT_DATA for a read
REQ-012 SHALL in WAIT_DATA, on read_data_valid=1, capture read_data into prdata and read_data_error into pslverr, then enter COMPLETE.
REQ-013 SHALL on acknowledge and read_data_valid sampled in the same REQUEST cycle of a read: capture the data then, and go directly to COMPLETE.
REQ-014 SHALL in COMPLETE drive pready=1 for exactly one cycle, then return to IDLE.
- pslverr=0 for writes.
- prdata=0 for writes.
REQ-015 SHALL hold pready=0 in every state other than COMPLETE, giving APB wait states.
REQ-016 SHALL ignore read_data_valid when not in WAIT_DATA or a read REQUEST.
REQ-017 SHALL ignore acknowledge when not in REQUEST.
REQ-018 SHALL complete an in-flight CSR transaction if psel drops mid-transfer (illegal APB).
- pready still pulses once.
- Return to IDLE.
REQ-019 SHALL not start a new setup while not IDLE; a back-to-back setup is accepted only from IDLE, the cycle after COMPLETE.
REQ-020 SHALL produce minimum latencies with a zero-wait target:
- Write: setup cycle t, valid at t+1, ack sampled t+1, pready at t+3.
- Read: read data one cycle after ack gives pready at t+4.
REQ-021 SHALL rely on a downstream timeout target for liveness and provide no internal watchdog.

Reset
REQ-022 SHALL on reset_n=0 asynchronously force:
- FSM=IDLE
- csr_request all fields 0
- pready=0, pslverr=0, prdata=0
REQ-023 SHALL on reset mid-transaction abandon it with no pready pulse; after release, the first APB setup is handled normally.

Structure
REQ-024 SHALL take t_csr_request, t_csr_response, t_apb_request and t_apb_response from the shared bus-types package.
REQ-025 SHALL keep the FSM state enumeration local to the module.
REQ-026 SHALL contain no sub-module; a single clocked process plus next-state logic is sufficient.

Verification
REQ-027 SHALL cover the write case:
- Stimulus: APB write paddr=0x0003_0010, pwdata=0xDEADBEEF, target acks 2 cycles after valid.
- Response: select=0x0003, address=0x0010, data=0xDEADBEEF held until ack; valid drops next cycle; one pready with pslverr=0.
REQ-028 SHALL cover the read case:
- Stimulus: APB read paddr=0x0001_0004, target acks, read_data=0x12345678 next cycle.
- Response: prdata=0x12345678, pslverr=0, pready one cycle after capture.
REQ-029 SHALL cover the timeout-target read:
- Stimulus: read with csr_timeout=4 target only.
- Response: ack after 4 cycles, then read_data_valid with error=1; pready with pslverr=1, prdata=0.
REQ-030 SHALL cover same-cycle ack and data:
- Stimulus: read, ack and read_data_valid together, data=0xA5A5A5A5.
- Response: WAIT_DATA skipped; pready next cycle with prdata=0xA5A5A5A5.
REQ-031 SHALL cover reset mid-operation:
- Stimulus: reset_n pulsed low while in REQUEST.
- Response: valid=0 immediately; no pready; subsequent write completes normally.
REQ-032 SHALL cover back-to-back transfers:
- Stimulus: write then read issued with minimum APB spacing.
- Response: two separate CSR requests, each valid dropping after its ack, and exactly two pready pulses.
